// File: rtl/hsv_core_pkg.sv
// rtl/hsv_core_pkg.sv - shared core types for commit, flush and commit-sink control
package hsv_core_pkg;

  typedef enum logic [2:0] {
    COMMIT_NEXT      = 3'd0,
    COMMIT_JUMP      = 3'd1,
    COMMIT_EXCEPTION = 3'd2,
    COMMIT_WFI       = 3'd3,
    COMMIT_MODE_RET  = 3'd4
  } commit_action_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        writeback;
  } commit_common_t;

  typedef struct packed {
    commit_common_t common;
    commit_action_t action;
    logic [31:0]    result;
    logic [31:0]    next_pc;
    logic [31:0]    trap_cause;
    logic [31:0]    trap_value;
  } commit_data_t;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    FLUSH_ENTER = 2'd1,
    FLUSH_EXIT  = 2'd2,
    WFI_WAIT    = 2'd3
  } commit_state_t;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_REQ  = 2'd1,
    FC_REL  = 2'd2
  } flush_state_t;

  function automatic logic is_redirect_action(commit_action_t a);
    return (a == COMMIT_JUMP) || (a == COMMIT_EXCEPTION) || (a == COMMIT_MODE_RET);
  endfunction

endpackage

// File: rtl/hsv_core_commit_sink_if.sv
// rtl/hsv_core_commit_sink_if.sv - commit beat channel between a unit skid buffer and the sink
interface hsv_core_commit_sink_if;
  import hsv_core_pkg::*;

  commit_data_t commit_data;
  logic         valid_i;
  logic         ready_o;

  modport master (output commit_data, output valid_i, input ready_o);
  modport slave  (input commit_data, input valid_i, output ready_o);

endinterface

// File: rtl/hsv_core_flush_ctrl.sv
// rtl/hsv_core_flush_ctrl.sv - four-phase flush req/ack initiator, shared with the control unit
module hsv_core_flush_ctrl
  import hsv_core_pkg::*;
(
  input  logic clk_core,
  input  logic rst_core,
  input  logic start,
  input  logic flush_ack,
  output logic flush_req,
  output logic busy
);

  flush_state_t state_q;
  flush_state_t state_d;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q <= FC_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Request stays up until ack rises, then stays down until ack falls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FC_IDLE: if (start)      state_d = FC_REQ;
      FC_REQ:  if (flush_ack)  state_d = FC_REL;
      FC_REL:  if (!flush_ack) state_d = FC_IDLE;
      default:                 state_d = FC_REQ;
    endcase
  end

  assign flush_req = (state_q == FC_REQ);
  assign busy      = (state_q != FC_IDLE);

endmodule

// File: rtl/hsv_core_commit_sink.sv
// rtl/hsv_core_commit_sink.sv - in-order commit receiver: RF writeback, redirects, traps, flush, WFI
module hsv_core_commit_sink
  import hsv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RETIRE_W = 64
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  hsv_core_commit_sink_if.slave commit,
  output logic                 flush_req,
  input  logic                 flush_ack,
  output logic                 rf_wr_en,
  output logic [4:0]           rf_wr_addr,
  output logic [31:0]          rf_wr_data,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  input  logic [31:0]          mtvec,
  input  logic [31:0]          mepc,
  output logic                 trap_valid,
  output logic [31:0]          trap_cause,
  output logic [31:0]          trap_value,
  output logic [31:0]          trap_pc,
  output logic                 mode_ret,
  input  logic                 irq_pending,
  output logic                 halted,
  output logic [RETIRE_W-1:0]  retired
);

  commit_state_t        state_q;
  commit_state_t        state_d;
  commit_data_t         beat;
  logic                 accept;
  logic                 do_redirect;
  logic                 do_retire;
  logic                 flush_busy;
  logic [31:0]          trap_base;
  logic [RETIRE_W-1:0]  retired_q;

  assign beat           = commit.commit_data;
  // The flush controller must be idle before beats are taken again.
  assign commit.ready_o = (state_q == RUN) && !flush_busy;
  assign accept         = commit.valid_i && commit.ready_o;
  assign do_redirect    = accept && is_redirect_action(beat.action);
  assign do_retire      = accept && (beat.action != COMMIT_EXCEPTION);
  assign trap_base      = mtvec & ~32'h3;
  assign halted         = (state_q == WFI_WAIT);
  assign retired        = retired_q;

  hsv_core_flush_ctrl u_flush_ctrl (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .start     (do_redirect),
    .flush_ack (flush_ack),
    .flush_req (flush_req),
    .busy      (flush_busy)
  );

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q <= FLUSH_ENTER;
    end else begin
      state_q <= state_d;
    end
  end

  // Interrupts seen during a flush are left to the control unit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (is_redirect_action(beat.action)) begin
            state_d = FLUSH_ENTER;
          end else if (beat.action == COMMIT_WFI) begin
            state_d = WFI_WAIT;
          end
        end
      end
      FLUSH_ENTER: if (flush_ack)   state_d = FLUSH_EXIT;
      FLUSH_EXIT:  if (!flush_ack)  state_d = RUN;
      WFI_WAIT:    if (irq_pending) state_d = RUN;
      default:                      state_d = FLUSH_ENTER;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      rf_wr_en       <= 1'b0;
      rf_wr_addr     <= 5'd0;
      rf_wr_data     <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      trap_valid     <= 1'b0;
      trap_cause     <= 32'd0;
      trap_value     <= 32'd0;
      trap_pc        <= 32'd0;
      mode_ret       <= 1'b0;
      retired_q      <= '0;
    end else begin
      rf_wr_en       <= do_retire && beat.common.writeback && (beat.common.rd != 5'd0);
      redirect_valid <= do_redirect;
      trap_valid     <= accept && (beat.action == COMMIT_EXCEPTION);
      mode_ret       <= accept && (beat.action == COMMIT_MODE_RET);
      if (do_retire) begin
        rf_wr_addr <= beat.common.rd;
        rf_wr_data <= beat.result;
        retired_q  <= retired_q + RETIRE_W'(1);
      end
      if (accept) begin
        case (beat.action)
          COMMIT_JUMP: redirect_pc <= beat.next_pc;
          COMMIT_EXCEPTION: begin
            redirect_pc <= trap_base;
            trap_cause  <= beat.trap_cause;
            trap_value  <= beat.trap_value;
            trap_pc     <= beat.common.pc;
          end
          COMMIT_MODE_RET: redirect_pc <= mepc;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/hsv_core_commit_sink.md
Name: hsv_core_commit_sink

Overview:
Commit-side receiver for one execution-unit output channel, consuming commit_data_t beats from the unit's skid buffer. It retires instructions in order, drives the register-file write port, and counts retirements. On COMMIT_JUMP, COMMIT_EXCEPTION or COMMIT_MODE_RET it redirects fetch and initiates the flush req-ack handshake toward the units. It also implements WFI halting.

Parameters:
RESET_PC, 32'h0000_0000, fetch target issued by the post-reset flush
RETIRE_W, 64, width of the retired-instruction counter

Ports:
clk_core  in  1  core clock
rst_core  in  1  synchronous reset, active-high
commit_data  in  $bits(commit_data_t)  beat from the unit skid buffer
valid_i  in  1  beat valid
ready_o  out  1  sink ready
flush_req  out  1  flush request to the units (req-ack initiator)
flush_ack  in  1  AND of all unit flush_ack signals
rf_wr_en  out  1  register-file write strobe
rf_wr_addr  out  5  destination register (common.rd)
rf_wr_data  out  32  write data
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  32  redirect target
mtvec  in  32  trap handler base
mepc  in  32  return target for MODE_RET
trap_valid  out  1  one-cycle pulse: latch mcause/mepc/mtval
trap_cause  out  32  cause from the beat
trap_value  out  32  value from the beat
trap_pc  out  32  common.pc of the trapping instruction
mode_ret  out  1  one-cycle pulse on MODE_RET retire
irq_pending  in  1  level-sensitive interrupt pending
halted  out  1  high while in WFI_WAIT
retired  out  RETIRE_W  retired-instruction count

Behaviour:
- Reset: all control updates apply on a clk_core edge with rst_core=1.
  - Values: state=FLUSH_ENTER, flush_req=1, redirect_valid=0, redirect_pc=RESET_PC, rf_wr_en=0, trap_valid=0, mode_ret=0, halted=0, retired=0, ready_o=0.
  - The first redirect after reset targets RESET_PC.
- States:
  - RUN: ready_o=1. A beat is accepted when valid_i & ready_o.
  - FLUSH_ENTER: flush_req=1. Move to FLUSH_EXIT on the cycle flush_ack=1 is sampled.
  - FLUSH_EXIT: flush_req=0. Move to RUN on the cycle flush_ack=0 is sampled.
  - WFI_WAIT: halted=1, ready_o=0. Move to RUN on the cycle irq_pending=1 is sampled.
- Handshake rules:
  - ready_o=0 in every state except RUN.
  - flush_req changes only on a state transition.
  - flush_req never flips again until flush_ack has matched it.
  - Beats are never consumed outside RUN. A beat presented during a flush is dropped by the unit's flush, not by this block.
- Accepted beat, registered outputs valid 1 cycle later:
  - Every action except EXCEPTION: rf_wr_en = writeback & (rd != 0), rf_wr_data=result, retired += 1 (wraps modulo 2^RETIRE_W).
  - NEXT: stay in RUN.
  - JUMP: redirect_valid=1, redirect_pc=next_pc; go to FLUSH_ENTER.
  - EXCEPTION: no register write, no retire increment.
    - trap_valid=1 with trap_cause/trap_value from the beat and trap_pc=common.pc.
    - redirect_pc = {mtvec[31:2],2'b00}; go to FLUSH_ENTER.
  - MODE_RET: mode_ret=1, redirect_pc=mepc; go to FLUSH_ENTER.
  - WFI: go to WFI_WAIT. If irq_pending is already 1, leave WFI_WAIT on the following cycle.
- Pulses: redirect_valid, trap_valid, mode_ret and rf_wr_en are single-cycle.
- Simultaneity and held inputs:
  - An irq arriving during a flush is ignored here; interrupt entry belongs to the control unit.
  - A flush_ack already equal to the new flush_req completes that handshake phase in one cycle.
- Reset mid-flush or mid-WFI: state returns to FLUSH_ENTER with flush_req=1; no pulse outputs are asserted during reset.

Decomposition:
- hsv_core_pkg holds:
  - commit_action_t (the existing NEXT/JUMP/EXCEPTION/WFI/MODE_RET encoding, already defined there)
  - commit_data_t
  - a new commit_state_t enum {RUN, FLUSH_ENTER, FLUSH_EXIT, WFI_WAIT}
- The flush handshake FSM is a natural sub-module, hsv_core_flush_ctrl.
  - Inputs: start, flush_ack.
  - Outputs: flush_req, busy.
  - This lets the control unit reuse it.

Test Plan:
- Reset: hold rst_core=1 for 2 cycles, release with flush_ack=1 -> flush_req=1 until ack sampled, then 0. After ack=0, ready_o=1 and the first redirect_pc is RESET_PC.
- NEXT with write: beat rd=5, writeback=1, result=32'h1234_5678 -> next cycle rf_wr_en=1, addr=5, data=32'h1234_5678, retired=1. Same beat with rd=0 -> rf_wr_en=0, retired=2.
- JUMP: beat next_pc=32'h0000_0400 -> redirect_valid=1, redirect_pc=32'h400, flush_req=1, ready_o=0.
  - Hold flush_ack=0 for 3 cycles; flush_req must stay 1.
  - Ack 1 then 0 -> ready_o=1.
- EXCEPTION: mtvec=32'h0000_0103, beat pc=32'h80, trap_cause=2, trap_value=32'hdead_c0de -> trap_valid=1, trap_pc=32'h80, redirect_pc=32'h100, rf_wr_en=0, retired unchanged.
- WFI: accept a WFI beat -> halted=1, ready_o=0 with valid_i held high for 10 cycles and nothing consumed. irq_pending=1 -> RUN the next cycle.
- Counter wrap: force retired to all-ones, retire one NEXT -> retired=0.
